// File: rtl/vme_rd_responder_if.sv
// vme_rd_responder_if
//   Bundles the VME read channel (command + return data) and the local
//   memory port of vme_rd_responder.
//   Signals:
//     io_vme_rd_cmd_valid/ready, io_vme_rd_cmd_bits_addr/len : read command
//     io_vme_rd_data_valid/ready, io_vme_rd_data_bits_data   : return beats
//     io_mem_en, io_mem_addr, io_mem_rdata                   : 1-cycle sync memory
//   Modports:
//     slave  : responder side (accepts commands, drives memory)
//     master : fetch client plus memory model side
interface vme_rd_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              io_vme_rd_cmd_valid;
  logic              io_vme_rd_cmd_ready;
  logic [ADDR_W-1:0] io_vme_rd_cmd_bits_addr;
  logic [7:0]        io_vme_rd_cmd_bits_len;
  logic              io_vme_rd_data_valid;
  logic              io_vme_rd_data_ready;
  logic [DATA_W-1:0] io_vme_rd_data_bits_data;
  logic              io_mem_en;
  logic [ADDR_W-1:0] io_mem_addr;
  logic [DATA_W-1:0] io_mem_rdata;

  modport slave (
    input  io_vme_rd_cmd_valid, io_vme_rd_cmd_bits_addr, io_vme_rd_cmd_bits_len,
           io_vme_rd_data_ready, io_mem_rdata,
    output io_vme_rd_cmd_ready, io_vme_rd_data_valid, io_vme_rd_data_bits_data,
           io_mem_en, io_mem_addr
  );

  modport master (
    output io_vme_rd_cmd_valid, io_vme_rd_cmd_bits_addr, io_vme_rd_cmd_bits_len,
           io_vme_rd_data_ready, io_mem_rdata,
    input  io_vme_rd_cmd_ready, io_vme_rd_data_valid, io_vme_rd_data_bits_data,
           io_mem_en, io_mem_addr
  );
endinterface

// File: rtl/vme_rd_responder.sv
// vme_rd_responder
//   Memory-side end of the VTA VME read channel. Accepts one (addr, len)
//   command at a time, reads len+1 beat-aligned words from a synchronous
//   1-cycle-latency memory and returns them in order through a small FIFO.
//   Ports:
//     clock, reset     : system clock, synchronous active-high reset
//     io (slave)       : command, return-data and memory signals
//     io_err_unaligned : sticky misaligned-command flag (VME_RD_ERR_CHECK_EN only)
//   Optional feature macro: VME_RD_ERR_CHECK_EN
module vme_rd_responder #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  vme_rd_responder_if.slave   io
`ifdef VME_RD_ERR_CHECK_EN
  ,
  output logic                io_err_unaligned
`endif
);

  localparam int BEAT_B = DATA_W / 8;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(BEAT_B);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BEAT_B - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [8:0]        issue_left_q, issue_left_d;
  logic [8:0]        send_left_q, send_left_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W:0]    occupancy;
  logic              accept, issue, push, pop;

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    mem_addr_d   = mem_addr_q;
    issue_left_d = issue_left_q;
    send_left_d  = send_left_q;
    fifo_d       = fifo_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;

    accept = (state_q == IDLE) && io.io_vme_rd_cmd_valid;
    // Outstanding words = buffered + the one still in the memory pipe;
    // issuing only below depth guarantees every response has a slot.
    occupancy = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
    issue     = (state_q == BUSY) && (issue_left_q != '0) &&
                (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    push      = inflight_q;
    pop       = (count_q != '0) && io.io_vme_rd_data_ready;
    inflight_d = issue;

    if (push) begin
      fifo_d[wr_ptr_q] = io.io_mem_rdata;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (accept) begin
          cur_addr_d   = io.io_vme_rd_cmd_bits_addr & ~OFF_MASK;
          issue_left_d = {1'b0, io.io_vme_rd_cmd_bits_len} + 9'd1;
          send_left_d  = {1'b0, io.io_vme_rd_cmd_bits_len} + 9'd1;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (issue) begin
          mem_addr_d   = cur_addr_q;
          cur_addr_d   = cur_addr_q + STRIDE;
          issue_left_d = issue_left_q - 9'd1;
        end
        if (pop) begin
          send_left_d = send_left_q - 9'd1;
          if (send_left_q == 9'd1) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      mem_addr_q   <= '0;
      issue_left_q <= '0;
      send_left_q  <= '0;
      inflight_q   <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      mem_addr_q   <= mem_addr_d;
      issue_left_q <= issue_left_d;
      send_left_q  <= send_left_d;
      inflight_q   <= inflight_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clock) begin
    fifo_q <= fifo_d;
  end

  assign io.io_vme_rd_cmd_ready      = (state_q == IDLE);
  assign io.io_vme_rd_data_valid     = (count_q != '0);
  assign io.io_vme_rd_data_bits_data = fifo_q[rd_ptr_q];
  assign io.io_mem_en                = issue;
  // Present the issuing address combinationally; otherwise hold the last one.
  assign io.io_mem_addr              = issue ? cur_addr_q : mem_addr_q;

`ifdef VME_RD_ERR_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (accept && ((io.io_vme_rd_cmd_bits_addr & OFF_MASK) != '0)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign io_err_unaligned = err_q;
`else
  // Misaligned low address bits are masked off at command accept.
`endif

endmodule

// File: tb/tb_vme_rd_responder.sv
// tb_vme_rd_responder
//   Directed bench for vme_rd_responder: single beat, 8-beat burst,
//   backpressure, address wrap, maximum length, reset mid-burst and
//   (with VME_RD_ERR_CHECK_EN) the sticky misalignment flag.
module tb_vme_rd_responder;

  logic clock;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic err_exp  = 1'b0;

  vme_rd_responder_if #(.ADDR_W(32), .DATA_W(64)) vif ();

`ifdef VME_RD_ERR_CHECK_EN
  logic err;
`endif

  vme_rd_responder #(
    .ADDR_W    (32),
    .DATA_W    (64),
    .FIFO_DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io   (vif)
`ifdef VME_RD_ERR_CHECK_EN
    ,
    .io_err_unaligned(err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 64'hA5A5_0000_0000_0001;
    return {~a, a};
  endfunction

  // Synchronous memory model, 1-cycle read latency.
  always @(posedge clock) begin
    if (vif.io_mem_en) vif.io_mem_rdata <= mem_word(vif.io_mem_addr);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // mode 0: data_ready held high; mode 1: ready follows 1-0-0-1 repeating.
  task automatic run_burst(input logic [31:0] a, input logic [7:0] l,
                           input int mode, input int max_cyc);
    logic [31:0] base;
    logic [31:0] nxt;
    logic [63:0] held;
    logic        stalled;
    int n, beats, issued, outstanding, first_issue, last_issue, last_beat;
    base = a & 32'hFFFF_FFF8;
    nxt  = base;
    n = int'(l) + 1;
    beats = 0; issued = 0; outstanding = 0;
    first_issue = -1; last_issue = -1; last_beat = -1;
    stalled = 1'b0; held = '0;

    @(negedge clock);
    check("idle_cmd_ready", 64'(vif.io_vme_rd_cmd_ready), 64'd1);
`ifdef VME_RD_ERR_CHECK_EN
    check("err_before_cmd", 64'(err), 64'(err_exp));
`endif
    vif.io_vme_rd_cmd_valid     = 1'b1;
    vif.io_vme_rd_cmd_bits_addr = a;
    vif.io_vme_rd_cmd_bits_len  = l;
    vif.io_vme_rd_data_ready    = 1'b1;
    if (a[2:0] != 3'b000) err_exp = 1'b1;

    for (int cyc = 1; cyc <= max_cyc && beats < n; cyc++) begin
      @(negedge clock);
      vif.io_vme_rd_cmd_valid  = 1'b0;
      vif.io_vme_rd_data_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      check("busy_cmd_ready", 64'(vif.io_vme_rd_cmd_ready), 64'd0);
`ifdef VME_RD_ERR_CHECK_EN
      if (cyc == 1) check("err_t1", 64'(err), 64'(err_exp));
`endif
      if (vif.io_mem_en) begin
        check("issue_addr", 64'(vif.io_mem_addr), 64'(nxt));
        check("credit", 64'(outstanding < 4), 64'd1);
        nxt = nxt + 32'd8;
        issued++;
        outstanding++;
        if (first_issue < 0) first_issue = cyc;
        last_issue = cyc;
      end
      if (stalled) begin
        check("stall_valid", 64'(vif.io_vme_rd_data_valid), 64'd1);
        check("stall_data", vif.io_vme_rd_data_bits_data, held);
      end
      if (vif.io_vme_rd_data_valid && vif.io_vme_rd_data_ready) begin
        check("beat_data", vif.io_vme_rd_data_bits_data, mem_word(base + 32'(beats * 8)));
        beats++;
        outstanding--;
        last_beat = cyc;
      end
      stalled = vif.io_vme_rd_data_valid && !vif.io_vme_rd_data_ready;
      held    = vif.io_vme_rd_data_bits_data;
    end

    check("beat_count", 64'(beats), 64'(n));
    check("issue_count", 64'(issued), 64'(n));
    if (mode == 0) begin
      check("first_issue_cyc", 64'(first_issue), 64'd1);
      check("last_issue_cyc", 64'(last_issue), 64'(n));
      check("last_beat_cyc", 64'(last_beat), 64'(n + 2));
    end
    @(negedge clock);
    check("done_cmd_ready", 64'(vif.io_vme_rd_cmd_ready), 64'd1);
    check("done_data_valid", 64'(vif.io_vme_rd_data_valid), 64'd0);
    check("done_mem_en", 64'(vif.io_mem_en), 64'd0);
    check("mem_addr_hold", 64'(vif.io_mem_addr), 64'(nxt - 32'd8));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    reset = 1'b1;
    vif.io_vme_rd_cmd_valid     = 1'b0;
    vif.io_vme_rd_cmd_bits_addr = '0;
    vif.io_vme_rd_cmd_bits_len  = '0;
    vif.io_vme_rd_data_ready    = 1'b0;
    vif.io_mem_rdata            = '0;
    repeat (3) @(negedge clock);
    check("rst_cmd_ready", 64'(vif.io_vme_rd_cmd_ready), 64'd1);
    check("rst_data_valid", 64'(vif.io_vme_rd_data_valid), 64'd0);
    check("rst_mem_en", 64'(vif.io_mem_en), 64'd0);
    check("rst_mem_addr", 64'(vif.io_mem_addr), 64'd0);
`ifdef VME_RD_ERR_CHECK_EN
    check("rst_err", 64'(err), 64'd0);
`endif
    reset = 1'b0;

    run_burst(32'h0000_0100, 8'd0,   0, 20);
    run_burst(32'h0000_1000, 8'd7,   0, 40);
    run_burst(32'h0000_2000, 8'd15,  1, 200);
    run_burst(32'hFFFF_FFF8, 8'd1,   0, 20);
    run_burst(32'h0000_4000, 8'd255, 0, 400);

`ifdef VME_RD_ERR_CHECK_EN
    run_burst(32'h0000_0104, 8'd0, 0, 20);
    repeat (3) @(negedge clock);
    check("err_sticky", 64'(err), 64'd1);
    run_burst(32'h0000_0200, 8'd1, 0, 20);
    check("err_sticky_after_aligned", 64'(err), 64'd1);
`endif

    // Reset in the middle of a 32-beat burst.
    @(negedge clock);
    vif.io_vme_rd_cmd_valid     = 1'b1;
    vif.io_vme_rd_cmd_bits_addr = 32'h0000_3000;
    vif.io_vme_rd_cmd_bits_len  = 8'd31;
    vif.io_vme_rd_data_ready    = 1'b1;
    beats = 0;
    for (int cyc = 0; cyc < 50 && beats < 5; cyc++) begin
      @(negedge clock);
      vif.io_vme_rd_cmd_valid = 1'b0;
      if (vif.io_vme_rd_data_valid && vif.io_vme_rd_data_ready) beats++;
    end
    check("pre_reset_beats", 64'(beats), 64'd5);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_data_valid", 64'(vif.io_vme_rd_data_valid), 64'd0);
    check("midrst_mem_en", 64'(vif.io_mem_en), 64'd0);
    check("midrst_cmd_ready", 64'(vif.io_vme_rd_cmd_ready), 64'd1);
    reset = 1'b0;
    err_exp = 1'b0;
`ifdef VME_RD_ERR_CHECK_EN
    check("midrst_err", 64'(err), 64'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("post_rst_quiet", 64'(vif.io_vme_rd_data_valid), 64'd0);
      check("post_rst_no_issue", 64'(vif.io_mem_en), 64'd0);
    end
    run_burst(32'h0000_0100, 8'd0, 0, 20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
